outport_arbiter: RTL and testbench

OUTPORT_ARBITER -- requirements
Module: outport_arbiter

---
 rtl/noc_pkg.sv | 17 +
 rtl/outport_arbiter_if.sv | 38 +++
 rtl/outport_arbiter_rr_pick.sv | 43 ++++
 rtl/outport_arbiter.sv | 105 ++++++++++
 tb/tb_outport_arbiter.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// Shared constants and state encoding for the output-port arbiter.
//   NPORT       : number of input-port requesters sharing one output port
//   IDXW        : width of the winner index (2**IDXW >= NPORT)
//   arb_state_e : arbiter FSM states
package noc_pkg;

    localparam int NPORT = 10;
    localparam int IDXW  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_CH = 2'd1,
        XFER   = 2'd2,
        HOLD   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/outport_arbiter_if.sv
// Handshake bundle between the input ports / downstream channel and the
// output-port arbiter.
//   req, tail       : per-port valid flit and tail/single-flit marker
//   full1, full2    : downstream VC0 / VC1 buffer full
//   gntDnStr        : downstream grants ownership of the bidirectional channel
//   reqDnStr        : arbiter requests ownership of the channel
//   gnt, sel        : one-hot grant and winner index (drives PacketOut mux)
//   vc_sel          : VC latched for the current packet
//   flit_vld        : a flit transfers this cycle
// modport slave is the arbiter side, modport master is the environment side.
interface outport_arbiter_if #(
    parameter int NPORT = noc_pkg::NPORT,
    parameter int IDXW  = noc_pkg::IDXW
) ();
    import noc_pkg::*;

    logic [NPORT-1:0] req;
    logic [NPORT-1:0] tail;
    logic             full1;
    logic             full2;
    logic             gntDnStr;
    logic             reqDnStr;
    logic [NPORT-1:0] gnt;
    logic [IDXW-1:0]  sel;
    logic             vc_sel;
    logic             flit_vld;

    modport slave (
        input  req, tail, full1, full2, gntDnStr,
        output reqDnStr, gnt, sel, vc_sel, flit_vld
    );

    modport master (
        output req, tail, full1, full2, gntDnStr,
        input  reqDnStr, gnt, sel, vc_sel, flit_vld
    );

endinterface

// File: rtl/outport_arbiter_rr_pick.sv
// Combinational round-robin pick: first requesting port found searching
// upward from ptr, wrapping after NPORT-1.
//   req     : request vector
//   ptr     : highest-priority port this round (must be < NPORT)
//   win_oh  : one-hot winner (zero when no request)
//   win_idx : winner index
//   win_any : at least one request present
module rr_pick #(
    parameter int NPORT = noc_pkg::NPORT,
    parameter int IDXW  = noc_pkg::IDXW
) (
    input  logic [NPORT-1:0] req,
    input  logic [IDXW-1:0]  ptr,
    output logic [NPORT-1:0] win_oh,
    output logic [IDXW-1:0]  win_idx,
    output logic             win_any
);
    import noc_pkg::*;

    int              j;
    logic [IDXW-1:0] idx;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        win_any = 1'b0;
        j       = 0;
        idx     = '0;
        for (int k = 0; k < NPORT; k++) begin
            j = int'(ptr) + k;
            if (j >= NPORT) begin
                j = j - NPORT;
            end
            idx = IDXW'(j);
            if (!win_any && req[idx]) begin
                win_any     = 1'b1;
                win_oh[idx] = 1'b1;
                win_idx     = idx;
            end
        end
    end

endmodule

// File: rtl/outport_arbiter.sv
// Output-port arbiter: acquires the bidirectional downstream channel, picks
// one input port round-robin, and holds that grant until the packet's tail
// flit transfers. Flit data does not pass through here; sel steers the mux.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : handshake bundle (slave side)
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no requests, channel not requested
// REQ_CH | requesting channel; arbitrate once channel granted and a VC free
// XFER   | packet in flight on latched port/VC
// HOLD   | channel taken away mid-packet; grant kept, no transfer
module outport_arbiter #(
    parameter int NPORT = noc_pkg::NPORT,
    parameter int IDXW  = noc_pkg::IDXW
) (
    input  logic                clk,
    input  logic                rst,
    outport_arbiter_if.slave    bus
);
    import noc_pkg::*;

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_REQ_CH = REQ_CH;
    localparam logic [1:0] ST_XFER   = XFER;
    localparam logic [1:0] ST_HOLD   = HOLD;

    logic [1:0]       state_q, state_d;
    logic [IDXW-1:0]  ptr_q, sel_q;
    logic [NPORT-1:0] gnt_q;
    logic             vc_q;

    logic [NPORT-1:0] pick_oh;
    logic [IDXW-1:0]  pick_idx;
    logic             pick_any;

    logic             vc_full, flit_vld, tail_xfer, others_req, can_grant;
    logic [IDXW-1:0]  ptr_next;

    rr_pick #(.NPORT(NPORT), .IDXW(IDXW)) u_rr_pick (
        .req     (bus.req),
        .ptr     (ptr_q),
        .win_oh  (pick_oh),
        .win_idx (pick_idx),
        .win_any (pick_any)
    );

    // The VC is fixed for the whole packet, so only its own full flag gates.
    assign vc_full    = vc_q ? bus.full2 : bus.full1;
    assign flit_vld   = (state_q == ST_XFER) && bus.req[sel_q] && bus.gntDnStr && !vc_full;
    assign tail_xfer  = flit_vld && bus.tail[sel_q];
    assign others_req = |(bus.req & ~gnt_q);
    assign can_grant  = bus.gntDnStr && (!bus.full1 || !bus.full2) && pick_any;
    assign ptr_next   = (sel_q == IDXW'(NPORT - 1)) ? '0 : sel_q + 1'b1;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (|bus.req) state_d = ST_REQ_CH;
            end
            ST_REQ_CH: begin
                if (~|bus.req)     state_d = ST_IDLE;
                else if (can_grant) state_d = ST_XFER;
            end
            ST_XFER: begin
                if (tail_xfer)          state_d = others_req ? ST_REQ_CH : ST_IDLE;
                else if (!bus.gntDnStr) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (bus.gntDnStr) state_d = ST_XFER;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            gnt_q   <= '0;
            vc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_REQ_CH && state_d == ST_XFER) begin
                gnt_q <= pick_oh;
                sel_q <= pick_idx;
                vc_q  <= bus.full1;     // VC0 preferred, VC1 only if VC0 full
            end
            if (tail_xfer) begin
                gnt_q <= '0;
                ptr_q <= ptr_next;
            end
        end
    end

    assign bus.reqDnStr = (state_q != ST_IDLE);
    assign bus.gnt      = gnt_q;
    assign bus.sel      = sel_q;
    assign bus.vc_sel   = vc_q;
    assign bus.flit_vld = flit_vld;

endmodule

// File: tb/tb_outport_arbiter.sv
module tb_outport_arbiter;
    import noc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    outport_arbiter_if #(.NPORT(NPORT), .IDXW(IDXW)) bus ();

    outport_arbiter #(.NPORT(NPORT), .IDXW(IDXW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [IDXW-1:0] port;
        logic            vc;
    } exp_t;

    exp_t             exp_q[$];
    exp_t             e;
    logic [NPORT-1:0] exp_oh;
    int               errors = 0;
    int               checks = 0;
    int               flits  = 0;
    int               base   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_flits(input int port, input int vc, input int n);
        exp_t x;
        x.port = IDXW'(port);
        x.vc   = 1'(vc);
        repeat (n) exp_q.push_back(x);
    endtask

    task automatic wait_flits(input int target, input int budget, input string name);
        int c = 0;
        while (flits < target && c < budget) begin
            step(1);
            c++;
        end
        checks++;
        if (flits < target) begin
            errors++;
            $display("FAIL %s: got %0d flits expected %0d within %0d cycles", name, flits, target, budget);
        end
    endtask

    task automatic idle_inputs();
        bus.req      = '0;
        bus.tail     = '0;
        bus.full1    = 1'b0;
        bus.full2    = 1'b0;
        bus.gntDnStr = 1'b1;
    endtask

    task automatic do_reset(input string name);
        idle_inputs();
        rst = 1'b0;
        step(2);
        check(name, 32'({bus.reqDnStr, bus.gnt, bus.sel, bus.vc_sel, bus.flit_vld}), 32'h0);
        rst = 1'b1;
    endtask

    // Scoreboard monitor: every transferred flit must match the next expected entry.
    always @(negedge clk) begin
        if (rst && bus.flit_vld) begin
            flits++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_flit: got port %0d vc %0d expected no flit", bus.sel, bus.vc_sel);
            end else begin
                e      = exp_q.pop_front();
                exp_oh = '0;
                exp_oh[e.port] = 1'b1;
                if (bus.gnt !== exp_oh || bus.sel !== e.port || bus.vc_sel !== e.vc) begin
                    errors++;
                    $display("FAIL flit_%0d: got gnt=%h sel=%0d vc=%0d expected gnt=%h sel=%0d vc=%0d",
                             flits, bus.gnt, bus.sel, bus.vc_sel, exp_oh, e.port, e.vc);
                end
            end
        end
    end

    initial begin
        // Reset state
        do_reset("reset_outputs");

        // Scenario 1: single 3-flit packet from port 0
        base = flits;
        expect_flits(0, 0, 3);
        bus.req = 10'h001;
        step(1);
        check("s1_reqdnstr", 32'(bus.reqDnStr), 32'd1);
        check("s1_no_early_gnt", 32'(bus.gnt), 32'h0);
        step(1);
        check("s1_gnt", 32'(bus.gnt), 32'h001);
        check("s1_sel", 32'(bus.sel), 32'd0);
        check("s1_vc", 32'(bus.vc_sel), 32'd0);
        wait_flits(base + 2, 3, "s1_first_two");
        bus.tail = 10'h001;
        wait_flits(base + 3, 2, "s1_tail");
        check("s1_idle", 32'({bus.reqDnStr, bus.gnt}), 32'h0);
        idle_inputs();
        step(2);
        check("s1_drain", 32'(exp_q.size()), 32'd0);

        // Scenario 2: all ports requesting single-flit packets from ptr=0
        do_reset("s2_reset");
        base = flits;
        for (int p = 0; p < NPORT; p++) expect_flits(p, 0, 1);
        expect_flits(0, 0, 1);
        bus.req  = 10'h3FF;
        bus.tail = 10'h3FF;
        wait_flits(base + NPORT + 1, 40, "s2_rr");
        idle_inputs();
        step(3);
        check("s2_drain", 32'(exp_q.size()), 32'd0);
        check("s2_idle", 32'(bus.reqDnStr), 32'd0);

        // Scenario 3: VC0 full at grant -> VC1 latched and kept
        base = flits;
        expect_flits(1, 1, 2);
        bus.full1 = 1'b1;
        bus.req   = 10'h002;
        step(2);
        check("s3_gnt", 32'(bus.gnt), 32'h002);
        check("s3_vc1", 32'(bus.vc_sel), 32'd1);
        step(1);
        check("s3_first_flit", 32'(flits - base), 32'd1);
        bus.full1 = 1'b0;
        bus.full2 = 1'b1;
        #1;
        check("s3_stall", 32'(bus.flit_vld), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("s3_stall_hold", 32'({bus.flit_vld, bus.vc_sel, bus.gnt}), 32'({1'b0, 1'b1, 10'h002}));
        end
        bus.full2 = 1'b0;
        bus.tail  = 10'h002;
        wait_flits(base + 2, 3, "s3_tail");
        idle_inputs();
        step(2);
        check("s3_drain", 32'(exp_q.size()), 32'd0);

        // Scenario 4: channel taken away for 4 cycles mid-packet
        base = flits;
        expect_flits(2, 0, 3);
        bus.req = 10'h004;
        step(3);
        check("s4_first_flit", 32'(flits - base), 32'd1);
        bus.gntDnStr = 1'b0;
        #1;
        check("s4_drop", 32'(bus.flit_vld), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("s4_hold", 32'({bus.flit_vld, bus.reqDnStr, bus.gnt}), 32'({1'b0, 1'b1, 10'h004}));
        end
        check("s4_no_flit_in_hold", 32'(flits - base), 32'd1);
        bus.gntDnStr = 1'b1;
        wait_flits(base + 2, 3, "s4_resume");
        bus.tail = 10'h004;
        wait_flits(base + 3, 2, "s4_tail");
        idle_inputs();
        step(2);
        check("s4_drain", 32'(exp_q.size()), 32'd0);

        // Scenario 5: reset in the middle of a packet
        bus.req = 10'h008;
        step(2);
        check("s5_in_xfer", 32'(bus.flit_vld), 32'd1);
        rst = 1'b0;
        #1;
        check("s5_abort", 32'({bus.gnt, bus.reqDnStr, bus.flit_vld}), 32'h0);
        step(1);
        base = flits;
        expect_flits(4, 0, 1);
        bus.req  = 10'h010;
        bus.tail = 10'h010;
        rst      = 1'b1;
        wait_flits(base + 1, 6, "s5_port4");
        idle_inputs();
        step(2);
        check("s5_drain", 32'(exp_q.size()), 32'd0);

        // Scenario 6: ptr at 9 wraps to 0
        base = flits;
        expect_flits(8, 0, 1);
        bus.req  = 10'h100;
        bus.tail = 10'h100;
        wait_flits(base + 1, 6, "s6_setup");
        idle_inputs();
        step(2);
        base = flits;
        expect_flits(9, 0, 1);
        expect_flits(0, 0, 1);
        bus.req  = 10'h201;
        bus.tail = 10'h201;
        wait_flits(base + 2, 10, "s6_wrap");
        idle_inputs();
        step(3);
        check("s6_drain", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
